// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to DMA_REG copies DMA_LEN bytes from page
// {rSrc,00} to OAM_BASE, one read cycle and one write cycle per byte.
module oam_dma #(
  parameter logic [15:0] DMA_REG  = 16'hFF46,
  parameter int          DMA_LEN  = 160,
  parameter logic [15:0] OAM_BASE = 16'hFE00
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iCpuAddr,
  input  logic        iCpuWe,
  input  logic [7:0]  iCpuData,
  output logic [7:0]  oCpuData,
  output logic [15:0] oAddr,
  output logic        oWe,
  output logic [7:0]  oData,
  input  logic [7:0]  iData,
  output logic        oDmaBusy
);

  // state | meaning
  // IDLE  | CPU owns the MMU bus, pass-through
  // READ  | fetch source byte {rSrc,rIdx} into rByte
  // WRITE | store rByte to OAM_BASE+rIdx
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  logic [1:0] state, state_nxt;
  logic [7:0] rSrc, rIdx, rByte;
  logic [7:0] src_nxt, idx_nxt, byte_nxt;
  logic       busy;
  logic       hit;
  logic       trigger;

  assign hit     = (iCpuAddr == DMA_REG);
  assign trigger = iCpuWe && hit;

  always_comb begin
    state_nxt = state;
    src_nxt   = rSrc;
    idx_nxt   = rIdx;
    byte_nxt  = rByte;
    case (state)
      READ: begin
        byte_nxt  = iData;
        state_nxt = WRITE;
      end
      WRITE: begin
        if (rIdx == LAST_IDX) begin
          state_nxt = IDLE;
        end else begin
          idx_nxt   = rIdx + 8'd1;
          state_nxt = READ;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A trigger always wins, including mid-transfer; the current write still
    // goes out because outputs depend only on the present state.
    if (trigger) begin
      src_nxt   = iCpuData;
      idx_nxt   = 8'd0;
      state_nxt = READ;
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state <= IDLE;
      rSrc  <= 8'h00;
      rIdx  <= 8'h00;
      rByte <= 8'h00;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      rSrc  <= src_nxt;
      rIdx  <= idx_nxt;
      rByte <= byte_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  assign oDmaBusy = busy;

  always_comb begin
    oAddr    = iCpuAddr;
    oData    = iCpuData;
    oWe      = iCpuWe && !hit;
    oCpuData = hit ? rSrc : iData;
    if (busy) begin
      oCpuData = hit ? rSrc : 8'hFF;
    end
    case (state)
      READ: begin
        oAddr = {rSrc, rIdx};
        oWe   = 1'b0;
        oData = rByte;
      end
      WRITE: begin
        oAddr = OAM_BASE + {8'h00, rIdx};
        oWe   = 1'b1;
        oData = rByte;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: transaction-level model (cycle counter per transfer,
// reference memory) checked every cycle, plus directed literal checks.
module tb_oam_dma;

  localparam int LEN = 160;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic [15:0] iCpuAddr = 16'hFF46;
  logic        iCpuWe = 1'b0;
  logic [7:0]  iCpuData = 8'h00;
  logic [7:0]  oCpuData, oData, iData;
  logic [15:0] oAddr;
  logic        oWe, oDmaBusy;

  logic [7:0]  oCpuData1, oData1, iData1;
  logic [15:0] oAddr1;
  logic        oWe1, oDmaBusy1;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  int n_pass = 0;
  int n_total = 0;
  bit run_chk = 0;

  bit       m_busy = 0;
  int       m_cnt = 0;
  logic [7:0] m_src = 8'h00;

  oam_dma u0 (
    .iClock(iClock), .iReset(iReset), .iCpuAddr(iCpuAddr), .iCpuWe(iCpuWe),
    .iCpuData(iCpuData), .oCpuData(oCpuData), .oAddr(oAddr), .oWe(oWe),
    .oData(oData), .iData(iData), .oDmaBusy(oDmaBusy)
  );

  oam_dma #(.DMA_LEN(1)) u1 (
    .iClock(iClock), .iReset(iReset), .iCpuAddr(iCpuAddr), .iCpuWe(iCpuWe),
    .iCpuData(iCpuData), .oCpuData(oCpuData1), .oAddr(oAddr1), .oWe(oWe1),
    .oData(oData1), .iData(iData1), .oDmaBusy(oDmaBusy1)
  );

  always #5 iClock = ~iClock;

  assign iData  = mem[oAddr];
  assign iData1 = oAddr1[7:0] ^ 8'h5A;

  always @(posedge iClock) if (oWe) mem[oAddr] <= oData;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: a transfer is a run of 2*LEN cycles; even cycles read, odd cycles write.
  always @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      m_busy <= 0;
      m_cnt  <= 0;
      m_src  <= 8'h00;
    end else begin
      if (m_busy && (m_cnt % 2 == 1))
        ref_mem[16'hFE00 + 16'(m_cnt / 2)] <= ref_mem[{m_src, 8'(m_cnt / 2)}];
      if (iCpuWe && iCpuAddr == 16'hFF46) begin
        m_busy <= 1;
        m_cnt  <= 0;
        m_src  <= iCpuData;
      end else if (m_busy) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt + 1 == 2 * LEN) m_busy <= 0;
      end else if (iCpuWe) begin
        ref_mem[iCpuAddr] <= iCpuData;
      end
    end
  end

  always @(negedge iClock) begin : cmp
    int b;
    if (run_chk) begin
      b = m_cnt / 2;
      chk("busy", oDmaBusy, m_busy);
      if (!m_busy) begin
        chk("pt_addr", oAddr, iCpuAddr);
        chk("pt_we", oWe, iCpuWe && iCpuAddr != 16'hFF46);
        chk("pt_data", oData, iCpuData);
        chk("pt_rd", oCpuData, iCpuAddr == 16'hFF46 ? m_src : ref_mem[iCpuAddr]);
      end else begin
        chk("busy_rd", oCpuData, iCpuAddr == 16'hFF46 ? m_src : 8'hFF);
        if (m_cnt % 2 == 0) begin
          chk("rd_addr", oAddr, {m_src, 8'(b)});
          chk("rd_we", oWe, 1'b0);
        end else begin
          chk("wr_addr", oAddr, 16'hFE00 + 16'(b));
          chk("wr_we", oWe, 1'b1);
          chk("wr_data", oData, ref_mem[{m_src, 8'(b)}]);
        end
      end
    end
  end

  task automatic cyc(input logic [15:0] a, input logic we, input logic [7:0] d);
    @(posedge iClock);
    #1;
    iCpuAddr = a;
    iCpuWe   = we;
    iCpuData = d;
    @(negedge iClock);
  endtask

  initial begin
    int busy;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'(i * 7);
      ref_mem[i] = 8'(i * 7);
    end
    for (int i = 0; i < LEN; i++) begin
      mem[16'hC000 + i]     = 8'(i) ^ 8'hA5;
      ref_mem[16'hC000 + i] = 8'(i) ^ 8'hA5;
      mem[16'hD000 + i]     = 8'(i) ^ 8'h3C;
      ref_mem[16'hD000 + i] = 8'(i) ^ 8'h3C;
    end
    #1 iReset = 1'b0;
    run_chk = 1;
    @(negedge iClock);
    chk("rst_busy", oDmaBusy, 1'b0);
    chk("rst_reg_rd", oCpuData, 8'h00);

    // Pass-through write
    @(posedge iClock);
    #1;
    iReset = 1'b1;
    iCpuAddr = 16'h8010; iCpuWe = 1'b1; iCpuData = 8'h5A;
    @(negedge iClock);
    chk("pt_lit_addr", oAddr, 16'h8010);
    chk("pt_lit_we", oWe, 1'b1);
    chk("pt_lit_data", oData, 8'h5A);
    chk("pt_lit_busy", oDmaBusy, 1'b0);
    cyc(16'h1234, 0, 8'h00);
    chk("pt_mem", mem[16'h8010], 8'h5A);

    // Full copy with bus lockout; LEN=1 instance triggers on the same write
    cyc(16'hFF46, 1, 8'hC0);
    chk("trig_no_fwd", oWe, 1'b0);
    busy = 0;
    for (int n = 0; n < 400; n++) begin
      case (n)
        20:      cyc(16'hC000, 1, 8'h11);
        21:      cyc(16'h8000, 0, 8'h00);
        22:      cyc(16'hFF46, 0, 8'h00);
        default: cyc(16'h1234, 0, 8'h00);
      endcase
      if (n == 0) begin
        chk("l1_busy0", oDmaBusy1, 1'b1);
        chk("l1_we0", oWe1, 1'b0);
        chk("l1_addr0", oAddr1, 16'hC000);
      end
      if (n == 1) begin
        chk("l1_busy1", oDmaBusy1, 1'b1);
        chk("l1_we1", oWe1, 1'b1);
        chk("l1_addr1", oAddr1, 16'hFE00);
        chk("l1_data1", oData1, 8'h5A);
      end
      if (n == 2) chk("l1_done", oDmaBusy1, 1'b0);
      if (n == 20) chk("lock_we", oWe, 1'b0);
      if (n == 21) chk("lock_rd", oCpuData, 8'hFF);
      if (n == 22) chk("reg_rd", oCpuData, 8'hC0);
      if (!oDmaBusy) break;
      busy++;
    end
    chk("busy_cycles", 16'(busy), 16'd320);
    chk("after_pt", oAddr, 16'h1234);
    for (int i = 0; i < LEN; i++) chk("oam_c0", mem[16'hFE00 + i], 8'(i) ^ 8'hA5);
    chk("lock_src", mem[16'hC000], 8'hA5);

    // Restart during the write of byte 50
    cyc(16'hFF46, 1, 8'hC0);
    busy = 0;
    for (int n = 0; n < 500; n++) begin
      if (n == 101) cyc(16'hFF46, 1, 8'hD0);
      else cyc(16'h1234, 0, 8'h00);
      if (n == 101) begin
        chk("rs_we", oWe, 1'b1);
        chk("rs_addr", oAddr, 16'hFE32);
        chk("rs_data", oData, 8'h97);
      end
      if (n == 102) chk("rs_idx0", oAddr, 16'hD000);
      if (!oDmaBusy) break;
      busy++;
    end
    chk("rs_busy_cycles", 16'(busy), 16'd422);
    for (int i = 0; i < LEN; i++) chk("oam_d0", mem[16'hFE00 + i], 8'(i) ^ 8'h3C);

    // Reset at cycle 100 of a transfer
    cyc(16'hFF46, 1, 8'hC0);
    for (int n = 0; n < 100; n++) cyc(16'h1234, 0, 8'h00);
    chk("pre_rst_busy", oDmaBusy, 1'b1);
    @(posedge iClock);
    #1;
    iReset = 1'b0;
    @(negedge iClock);
    chk("mid_rst_busy", oDmaBusy, 1'b0);
    chk("mid_rst_we", oWe, 1'b0);
    cyc(16'h1234, 0, 8'h00);
    @(posedge iClock);
    #1;
    iReset = 1'b1;
    iCpuAddr = 16'hFF46;
    @(negedge iClock);
    chk("post_rst_reg", oCpuData, 8'h00);
    repeat (4) cyc(16'h1234, 0, 8'h00);
    chk("post_rst_busy", oDmaBusy, 1'b0);
    chk("rst_kept", mem[16'hFE31], 8'h94);
    chk("rst_no_partial", mem[16'hFE32], 8'h0E);

    run_chk = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
